i2s_frame_lock_ctrl: RTL and testbench
======================================

// Module: i2s_frame_lock_ctrl
// PURPOSE
//  Lock/mute sequencer for the I2S->16LJ conversion path. Measures frame length and duty
//  of the incoming LRCK in BCK cycles, classifies the format as 32/48/64fs, and gates the
//  converter (conv_en) and output mute. The converter is enabled, and the output unmuted,
//  only after a stable lock plus a settle window. Sits beside the converter in the BCK domain.
// PARAMETERS
//  LOCK_FRAMES  4   consecutive identical valid frames required to lock
//  MUTE_FRAMES  8   frames mute is held after conv_en rises (settle window)
//  CNT_W        7   width of BCK-per-frame counter (saturates at 2**CNT_W-1)
//  ERR_W        8   width of lock-loss error counter
// PORTS
//  bck         in   1      sole clock; all logic on posedge bck
//  rst_n       in   1      asynchronous, active-low reset
//  lrck        in   1      incoming I2S frame sync, synchronous to bck
//  force_mute  in   1      external mute request; does not affect FSM
//  err_clr     in   1      synchronous clear of err_cnt
//  conv_en     out  1      enable/hold-off for the converter datapath
//  mute        out  1      1 = output muted
//  locked      out  1      1 in LOCKED state only
//  sync_pulse  out  1      one-cycle pulse on entry to SETTLE (converter realign)
//  fs_mode     out  2      00=32fs 01=48fs 10=64fs 11=unknown/unlocked
//  err_cnt     out  ERR_W  saturating count of lock losses
// BEHAVIOUR
//  Reset values: conv_en=0 mute=1 locked=0 sync_pulse=0 fs_mode=11 err_cnt=0, state IDLE,
//   lrck_q=0, cnt=0, match=0, ref_len=0. Reset asserted mid-operation returns all of these at once.
//  Edge detect: rise = lrck & ~lrck_q; fall = ~lrck & lrck_q; lrck_q <= lrck each edge.
//  Counter: on rise cnt<=1; else cnt<=cnt+1, saturating at 2**CNT_W-1 (timeout value).
//   On fall, capture H<=cnt. On rise, L=cnt (current value, before reload) is the frame length.
//  Frame valid: L in {32,48,64} AND 2*H==L AND no timeout since previous rise.
//  Timeout: cnt==2**CNT_W-1 with no rise seen.
//  FSM (state register updates on the edge where the event is sampled):
//   IDLE: first rise -> MEASURE, match=0.
//   MEASURE: on rise: valid & L==ref_len -> match++; valid & L!=ref_len -> ref_len<=L, match=1;
//     invalid -> match=0. When match reaches LOCK_FRAMES -> SETTLE, sync_pulse=1 next cycle.
//     Timeout -> IDLE.
//   SETTLE: conv_en=1, mute=1, fs_mode=class(ref_len). Counts MUTE_FRAMES rises with valid,
//     matching frames -> LOCKED.
//   LOCKED: conv_en=1, mute=force_mute, locked=1.
//   Loss (SETTLE/LOCKED): invalid frame or L!=ref_len -> MEASURE (match=0, ref_len=0);
//     timeout -> IDLE. Either way err_cnt+1 (saturating), conv_en=0, mute=1, locked=0,
//     fs_mode=11 on the following cycle.
//  All outputs registered: they change 1 bck after the sampled rise/timeout. mute is 1 in
//   IDLE/MEASURE/SETTLE regardless of force_mute; force_mute reaches mute 1 cycle after assertion.
//  err_clr together with a loss event: err_cnt <= 1. err_clr alone: err_cnt <= 0.
//  Loss on the same rise that would complete the settle window: loss wins.
// TESTING
//  1 64fs LRCK (32 hi/32 lo) from reset -> sync_pulse at rise#5+1 cycle, locked/mute=0 at
//    rise#13+1, fs_mode=10.
//  2 48fs and 32fs streams -> fs_mode=01 / 00, same rise counts to lock.
//  3 Locked 64fs, one frame of 63 BCK -> next cycle conv_en=0 mute=1 err_cnt=1, state MEASURE;
//    relock after 4 further good frames.
//  4 Hold lrck at 0 while locked -> timeout at cnt=127, state IDLE, fs_mode=11, err_cnt++.
//  5 Asymmetric duty (H=30, L=64) repeated -> never leaves MEASURE, conv_en stays 0.
//  6 force_mute toggled while LOCKED -> mute follows with 1-cycle lag; locked stays 1.
//    rst_n pulsed low mid-SETTLE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/i2s_frame_lock_ctrl.sv
// LRCK frame-length/duty lock sequencer for the I2S->16LJ converter path.
// Classifies 32/48/64fs, then enables the converter and unmutes after a settle window.
module i2s_frame_lock_ctrl #(
  parameter int LOCK_FRAMES = 4,
  parameter int MUTE_FRAMES = 8,
  parameter int CNT_W       = 7,
  parameter int ERR_W       = 8
) (
  input  logic             bck,
  input  logic             rst_n,
  input  logic             lrck,
  input  logic             force_mute,
  input  logic             err_clr,
  output logic             conv_en,
  output logic             mute,
  output logic             locked,
  output logic             sync_pulse,
  output logic [1:0]       fs_mode,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam int SW = $clog2(MUTE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, SETTLE, LOCKED} state_t;

  state_t           state;
  logic             lrck_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] ref_len;
  logic [MW-1:0]    match;
  logic [SW-1:0]    settle_cnt;

  logic rise, fall, timeout, frame_ok, same_len, active, loss;

  function automatic logic [1:0] fs_class(input logic [CNT_W-1:0] len);
    case (len)
      CNT_W'(32): fs_class = 2'b00;
      CNT_W'(48): fs_class = 2'b01;
      CNT_W'(64): fs_class = 2'b10;
      default:    fs_class = 2'b11;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
    err_inc = (v == '1) ? v : v + 1'b1;
  endfunction

  assign rise     = lrck & ~lrck_q;
  assign fall     = ~lrck & lrck_q;
  assign timeout  = (cnt == CNT_MAX) && !rise;
  // A frame that timed out reads back as CNT_MAX, which never classifies as a valid length.
  assign frame_ok = (fs_class(cnt) != 2'b11) && ({h_len, 1'b0} == {1'b0, cnt});
  assign same_len = (cnt == ref_len);
  assign active   = (state == SETTLE) || (state == LOCKED);
  assign loss     = active && (timeout || (rise && !(frame_ok && same_len)));

  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lrck_q     <= 1'b0;
      cnt        <= '0;
      h_len      <= '0;
      ref_len    <= '0;
      match      <= '0;
      settle_cnt <= '0;
      conv_en    <= 1'b0;
      mute       <= 1'b1;
      locked     <= 1'b0;
      sync_pulse <= 1'b0;
      fs_mode    <= 2'b11;
      err_cnt    <= '0;
    end else begin
      lrck_q     <= lrck;
      sync_pulse <= 1'b0;
      if (rise)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (fall) h_len <= cnt;

      if (loss)         err_cnt <= err_clr ? ERR_W'(1) : err_inc(err_cnt);
      else if (err_clr) err_cnt <= '0;

      if (loss) begin
        state   <= timeout ? IDLE : MEASURE;
        match   <= '0;
        ref_len <= '0;
        conv_en <= 1'b0;
        mute    <= 1'b1;
        locked  <= 1'b0;
        fs_mode <= 2'b11;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= MEASURE;
              match <= '0;
            end
          end
          MEASURE: begin
            if (timeout) begin
              state <= IDLE;
              match <= '0;
            end else if (rise) begin
              if (frame_ok && same_len) begin
                match <= match + 1'b1;
                if (match == MW'(LOCK_FRAMES - 1)) begin
                  state      <= SETTLE;
                  sync_pulse <= 1'b1;
                  conv_en    <= 1'b1;
                  fs_mode    <= fs_class(ref_len);
                  settle_cnt <= '0;
                end
              end else if (frame_ok) begin
                ref_len <= cnt;
                match   <= MW'(1);
              end else begin
                match <= '0;
              end
            end
          end
          SETTLE: begin
            if (rise) begin
              if (settle_cnt == SW'(MUTE_FRAMES - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                mute   <= force_mute;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          LOCKED: mute <= force_mute;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_lock_ctrl.sv
// Scoreboard bench for i2s_frame_lock_ctrl: expected output snapshots are queued per
// LRCK rise/event and compared 1 ns after the bck edge they are due on.
module tb_i2s_frame_lock_ctrl;

  logic       bck = 1'b0;
  logic       rst_n = 1'b0;
  logic       lrck = 1'b0;
  logic       force_mute = 1'b0;
  logic       err_clr = 1'b0;
  logic       conv_en, mute, locked, sync_pulse;
  logic [1:0] fs_mode;
  logic [7:0] err_cnt;

  i2s_frame_lock_ctrl dut (
    .bck        (bck),
    .rst_n      (rst_n),
    .lrck       (lrck),
    .force_mute (force_mute),
    .err_clr    (err_clr),
    .conv_en    (conv_en),
    .mute       (mute),
    .locked     (locked),
    .sync_pulse (sync_pulse),
    .fs_mode    (fs_mode),
    .err_cnt    (err_cnt)
  );

  always #5 bck = ~bck;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] want;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_err = 8'd0;
  logic [13:0] got;

  assign got = {conv_en, mute, locked, sync_pulse, fs_mode, err_cnt};

  localparam logic [13:0] RST_VAL = {1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 8'h00};

  task automatic push_exp(input int c, input string tag, input logic ce, input logic mu,
                          input logic lk, input logic sp, input logic [1:0] fs, input logic [7:0] er);
    exp_t e;
    e.cyc  = c;
    e.tag  = tag;
    e.want = {ce, mu, lk, sp, fs, er};
    sb.push_back(e);
  endtask

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(posedge bck);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || got !== e.want) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d got={ce,mu,lk,sp,fs,err}=%h want=%h",
                   e.tag, cyc, e.cyc, got, e.want);
        end
      end
    end
  endtask

  // k counts rises as seen from reset: 1..4 measuring, 5 enters SETTLE, 13 enters LOCKED.
  task automatic run_frames(input int hi, input int lo, input int n, input int k0,
                            input logic [1:0] fs, input string tag);
    int k;
    for (int i = 0; i < n; i++) begin
      k = k0 + i;
      @(negedge bck);
      lrck = 1'b1;
      if (k <= 4)
        push_exp(cyc + 1, tag, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, exp_err);
      else if (k == 5) begin
        push_exp(cyc + 1, {tag, "_sync"}, 1'b1, 1'b1, 1'b0, 1'b1, fs, exp_err);
        push_exp(cyc + 2, {tag, "_sync_end"}, 1'b1, 1'b1, 1'b0, 1'b0, fs, exp_err);
      end else if (k <= 12)
        push_exp(cyc + 1, {tag, "_settle"}, 1'b1, 1'b1, 1'b0, 1'b0, fs, exp_err);
      else
        push_exp(cyc + 1, {tag, "_locked"}, 1'b1, 1'b0, 1'b1, 1'b0, fs, exp_err);
      repeat (hi - 1) @(negedge bck);
      @(negedge bck);
      lrck = 1'b0;
      repeat (lo - 1) @(negedge bck);
    end
  endtask

  task automatic do_reset();
    @(negedge bck);
    rst_n      = 1'b0;
    lrck       = 1'b0;
    force_mute = 1'b0;
    err_clr    = 1'b0;
    exp_err    = 8'd0;
    repeat (3) @(negedge bck);
    rst_n = 1'b1;
    @(negedge bck);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got !== RST_VAL) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", got, RST_VAL);
    end
  endtask

  task automatic test_lock_64();
    run_frames(32, 32, 14, 1, 2'b10, "lock64");
  endtask

  task automatic test_loss_63();
    run_frames(32, 31, 1, 14, 2'b10, "pre_loss");
    exp_err = 8'd1;
    run_frames(32, 32, 14, 1, 2'b10, "relock");
  endtask

  task automatic test_force_mute();
    @(negedge bck);
    lrck = 1'b1;
    repeat (10) @(negedge bck);
    checks++;
    if (mute !== 1'b0) begin
      failures++;
      $display("FAIL fm_before mute=%b want=0", mute);
    end
    force_mute = 1'b1;
    push_exp(cyc + 1, "fm_on", 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, exp_err);
    repeat (5) @(negedge bck);
    force_mute = 1'b0;
    push_exp(cyc + 1, "fm_off", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, exp_err);
    repeat (16) @(negedge bck);
    @(negedge bck);
    lrck = 1'b0;
    repeat (31) @(negedge bck);
  endtask

  task automatic test_timeout();
    int r;
    @(negedge bck);
    lrck = 1'b1;
    r = cyc + 1;
    push_exp(r, "to_rise", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, exp_err);
    push_exp(r + 126, "to_before", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, exp_err);
    exp_err = exp_err + 8'd1;
    push_exp(r + 127, "to_hit", 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, exp_err);
    repeat (31) @(negedge bck);
    @(negedge bck);
    lrck = 1'b0;
    repeat (140) @(negedge bck);
  endtask

  task automatic test_err_clr();
    @(negedge bck);
    err_clr = 1'b1;
    exp_err = 8'd0;
    push_exp(cyc + 1, "err_clr", 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 8'd0);
    @(negedge bck);
    err_clr = 1'b0;
    repeat (2) @(negedge bck);
  endtask

  task automatic test_formats();
    do_reset();
    run_frames(24, 24, 14, 1, 2'b01, "fmt48");
    do_reset();
    run_frames(16, 16, 14, 1, 2'b00, "fmt32");
  endtask

  task automatic test_duty();
    do_reset();
    run_frames(30, 34, 10, -20, 2'b11, "duty30");
  endtask

  task automatic test_reset_settle();
    do_reset();
    run_frames(32, 32, 6, 1, 2'b10, "pre_rst");
    @(negedge bck);
    lrck = 1'b1;
    repeat (3) @(negedge bck);
    checks++;
    if (conv_en !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL settle_state conv_en=%b locked=%b want 1/0", conv_en, locked);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== RST_VAL) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", got, RST_VAL);
    end
    lrck = 1'b0;
    repeat (2) @(negedge bck);
    rst_n = 1'b1;
    @(negedge bck);
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_lock_64();
    test_loss_63();
    test_force_mute();
    test_timeout();
    test_err_clr();
    test_formats();
    test_duty();
    test_reset_settle();
    repeat (3) @(negedge bck);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge bck);
    $display("FAIL watchdog cyc=%0d limit=30000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
